// File: rtl/usb_tx_nrzi_encoder.sv
// Final USB full-speed transmit stage: NRZI-encodes the stuffed bit stream,
// drives the differential pair and output enable, and appends SE0/J end-of-packet.
module usb_tx_nrzi_encoder #(
    parameter int SE0_BITS = 2,
    parameter int MAX_ONES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_strobe,
    input  logic tx_en,
    input  logic serial_in,
    input  logic stuffing,
    output logic d_plus,
    output logic d_minus,
    output logic d_oe,
    output logic busy,
    output logic eop_done,
    output logic stuff_err
);
    localparam int SE0_W = (SE0_BITS < 2) ? 1 : $clog2(SE0_BITS + 1);
    localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(SE0_BITS);
    localparam logic [2:0] ONES_LIMIT = 3'(MAX_ONES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SE0,
        EOP_J
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       ones_cnt_reg, ones_cnt_next;
    logic [SE0_W-1:0] se0_cnt_reg, se0_cnt_next;
    logic             d_plus_reg, d_plus_next;
    logic             d_minus_reg, d_minus_next;
    logic             d_oe_reg, d_oe_next;
    logic             busy_reg, busy_next;
    logic             eop_done_reg, eop_done_next;
    logic             stuff_err_reg, stuff_err_next;

    logic             enc_bit;
    logic [2:0]       ones_inc;

    assign enc_bit  = stuffing ? 1'b0 : serial_in;
    assign ones_inc = (ones_cnt_reg == 3'd7) ? 3'd7 : ones_cnt_reg + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ones_cnt_reg  <= '0;
            se0_cnt_reg   <= '0;
            d_plus_reg    <= 1'b1;
            d_minus_reg   <= 1'b0;
            d_oe_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            eop_done_reg  <= 1'b0;
            stuff_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ones_cnt_reg  <= ones_cnt_next;
            se0_cnt_reg   <= se0_cnt_next;
            d_plus_reg    <= d_plus_next;
            d_minus_reg   <= d_minus_next;
            d_oe_reg      <= d_oe_next;
            busy_reg      <= busy_next;
            eop_done_reg  <= eop_done_next;
            stuff_err_reg <= stuff_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ones_cnt_next  = ones_cnt_reg;
        se0_cnt_next   = se0_cnt_reg;
        d_plus_next    = d_plus_reg;
        d_minus_next   = d_minus_reg;
        d_oe_next      = d_oe_reg;
        busy_next      = busy_reg;
        eop_done_next  = 1'b0;
        stuff_err_next = stuff_err_reg;

        if (bit_strobe) begin
            case (state_reg)
                IDLE: begin
                    if (tx_en) begin
                        // First bit is always encoded against J, whatever the line held before.
                        state_next     = ACTIVE;
                        d_oe_next      = 1'b1;
                        busy_next      = 1'b1;
                        d_plus_next    = enc_bit;
                        d_minus_next   = ~enc_bit;
                        ones_cnt_next  = enc_bit ? 3'd1 : 3'd0;
                        stuff_err_next = enc_bit && (ONES_LIMIT == 3'd1);
                    end
                end
                ACTIVE: begin
                    if (tx_en) begin
                        if (enc_bit) begin
                            ones_cnt_next = ones_inc;
                            if (ones_inc == ONES_LIMIT) begin
                                stuff_err_next = 1'b1;
                            end
                        end else begin
                            ones_cnt_next = 3'd0;
                            d_plus_next   = ~d_plus_reg;
                            d_minus_next  = ~d_minus_reg;
                        end
                    end else begin
                        state_next   = SE0;
                        d_plus_next  = 1'b0;
                        d_minus_next = 1'b0;
                        se0_cnt_next = SE0_W'(1);
                    end
                end
                SE0: begin
                    if (se0_cnt_reg < SE0_LAST) begin
                        se0_cnt_next = se0_cnt_reg + SE0_W'(1);
                    end else begin
                        state_next   = EOP_J;
                        d_plus_next  = 1'b1;
                        d_minus_next = 1'b0;
                    end
                end
                EOP_J: begin
                    state_next    = IDLE;
                    d_oe_next     = 1'b0;
                    busy_next     = 1'b0;
                    eop_done_next = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign d_plus    = d_plus_reg;
    assign d_minus   = d_minus_reg;
    assign d_oe      = d_oe_reg;
    assign busy      = busy_reg;
    assign eop_done  = eop_done_reg;
    assign stuff_err = stuff_err_reg;
endmodule

// File: tb/tb_usb_tx_nrzi_encoder.sv
// Bench for usb_tx_nrzi_encoder: fixed SYNC/EOP vector table, hand-written corner
// sequences, and random packets checked against a packet-level reference model.
module tb_usb_tx_nrzi_encoder;
    localparam int SE0_BITS = 2;
    localparam int MAX_ONES = 6;

    logic tb_clk = 1'b0;
    logic rst = 1'b1;
    logic bit_strobe = 1'b0;
    logic tx_en = 1'b0;
    logic serial_in = 1'b0;
    logic stuffing = 1'b0;
    logic d_plus, d_minus, d_oe, busy, eop_done, stuff_err;

    always #5 tb_clk = ~tb_clk;

    usb_tx_nrzi_encoder #(.SE0_BITS(SE0_BITS), .MAX_ONES(MAX_ONES)) dut (
        .clk(tb_clk), .rst(rst), .bit_strobe(bit_strobe), .tx_en(tx_en),
        .serial_in(serial_in), .stuffing(stuffing), .d_plus(d_plus),
        .d_minus(d_minus), .d_oe(d_oe), .busy(busy), .eop_done(eop_done),
        .stuff_err(stuff_err)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: packet is the list of encoded bits sent so far; line level
    // follows from the parity of zeros, the error from the longest run of ones.
    int   mode = 0;         // 0 idle, 1 sending packet, 2 end-of-packet
    int   eop_k = 0;        // strobes since tx_en dropped
    logic exp_eop = 1'b0;
    logic pkt_bits[$];

    task automatic model_reset();
        mode = 0;
        eop_k = 0;
        exp_eop = 1'b0;
        pkt_bits.delete();
    endtask

    task automatic model_step(input logic tx, input logic b);
        exp_eop = 1'b0;
        case (mode)
            0: if (tx) begin
                mode = 1;
                pkt_bits.delete();
                pkt_bits.push_back(b);
            end
            1: if (tx) pkt_bits.push_back(b);
               else begin
                   mode = 2;
                   eop_k = 1;
               end
            default: begin
                eop_k++;
                if (eop_k == SE0_BITS + 2) begin
                    mode = 0;
                    exp_eop = 1'b1;
                end
            end
        endcase
    endtask

    function automatic logic [5:0] model_out();
        int zeros = 0;
        int run = 0;
        int maxrun = 0;
        logic err;
        logic lvl_j;
        foreach (pkt_bits[i]) begin
            if (pkt_bits[i]) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
                zeros++;
            end
        end
        err = (maxrun > MAX_ONES);
        lvl_j = (zeros % 2 == 0);
        case (mode)
            0: return {1'b1, 1'b0, 1'b0, 1'b0, exp_eop, err};
            1: return {lvl_j, ~lvl_j, 1'b1, 1'b1, 1'b0, err};
            default: return (eop_k <= SE0_BITS) ? {5'b00110, err} : {5'b10110, err};
        endcase
    endfunction

    function automatic logic [5:0] dut_out();
        return {d_plus, d_minus, d_oe, busy, eop_done, stuff_err};
    endfunction

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = dut_out();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: dp,dm,oe,busy,eop,err got %b want %b", name, got, exp);
        end
    endtask

    task automatic strobe(input logic tx, input logic sin, input logic st);
        @(negedge tb_clk);
        tx_en = tx;
        serial_in = sin;
        stuffing = st;
        bit_strobe = 1'b1;
        @(posedge tb_clk);
        #1;
        bit_strobe = 1'b0;
        model_step(tx, st ? 1'b0 : sin);
    endtask

    // Clocks without a strobe: everything holds except eop_done, which clears.
    task automatic gap(input int n, input string name);
        repeat (n) begin
            @(negedge tb_clk);
            tx_en = $urandom_range(0, 1);
            serial_in = $urandom_range(0, 1);
            stuffing = $urandom_range(0, 1);
            @(posedge tb_clk);
            #1;
            exp_eop = 1'b0;
            check(name, model_out());
        end
    endtask

    task automatic strobe_chk(input logic tx, input logic sin, input logic st, input string name);
        strobe(tx, sin, st);
        check(name, model_out());
        gap(1, {name, "_hold"});
    endtask

    task automatic end_packet();
        strobe_chk(1'b0, 1'b0, 1'b0, "eop_se0_a");
        strobe_chk($urandom_range(0, 1), 1'b0, 1'b0, "eop_se0_b");
        strobe_chk($urandom_range(0, 1), 1'b1, 1'b0, "eop_j");
        strobe_chk($urandom_range(0, 1), 1'b0, 1'b0, "eop_idle");
    endtask

    typedef struct {
        logic       tx;
        logic       sin;
        logic       st;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // SYNC then EOP; expected {dp,dm,oe,busy,eop_done,stuff_err}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b011100};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'b101100};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'b011100};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 6'b101100};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 6'b011100};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 6'b101100};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 6'b011100};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 6'b011100};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'b001100};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 6'b001100};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 6'b101100};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 6'b100010};

        model_reset();
        repeat (2) @(posedge tb_clk);
        #1;
        check("reset", 6'b100000);
        @(negedge tb_clk);
        rst = 1'b0;
        gap(2, "post_reset");

        for (int i = 0; i < 12; i++) begin
            strobe(tbl[i].tx, tbl[i].sin, tbl[i].st);
            check($sformatf("table_%0d", i), tbl[i].exp);
            gap(1, $sformatf("table_%0d_next", i));
        end

        // Seven ones without stuffing: error on the 7th, line static.
        strobe_chk(1'b1, 1'b0, 1'b0, "ones_lead");
        for (int i = 0; i < 6; i++) strobe_chk(1'b1, 1'b1, 1'b0, "ones_run");
        check("ones6_no_err", 6'b011100);
        strobe(1'b1, 1'b1, 1'b0);
        check("ones7_err", 6'b011101);
        gap(1, "ones7_hold");
        end_packet();
        check("err_sticky_idle", 6'b100001);

        // Same run but 7th bit stuffed: line toggles, no error.
        strobe_chk(1'b1, 1'b0, 1'b0, "stuff_lead");
        check("err_cleared_on_start", 6'b011100);
        for (int i = 0; i < 6; i++) strobe_chk(1'b1, 1'b1, 1'b0, "stuff_run");
        strobe(1'b1, 1'b1, 1'b1);
        check("stuffed_toggle", 6'b101100);
        gap(20, "no_strobe_hold");
        end_packet();

        // Reset during SE0.
        strobe_chk(1'b1, 1'b1, 1'b0, "rst_pkt_a");
        strobe_chk(1'b1, 1'b0, 1'b0, "rst_pkt_b");
        strobe_chk(1'b0, 1'b0, 1'b0, "rst_pkt_se0");
        @(negedge tb_clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async", 6'b100000);
        @(posedge tb_clk);
        #1;
        check("rst_held", 6'b100000);
        @(negedge tb_clk);
        rst = 1'b0;
        gap(3, "rst_no_eop");
        strobe(1'b1, 1'b0, 1'b0);
        check("restart_first_k", 6'b011100);
        gap(1, "restart_hold");
        end_packet();

        // Random packets against the model.
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 24);
            strobe_chk(1'b1, 1'b0, 1'b0, "rnd_first");
            for (int i = 0; i < len; i++) begin
                strobe_chk(1'b1, ($urandom % 5) != 0, ($urandom % 10) == 0, "rnd_bit");
                gap($urandom_range(0, 2), "rnd_gap");
            end
            end_packet();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                strobe_chk(1'b0, $urandom_range(0, 1), 1'b0, "rnd_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
